// File: rtl/vc_arbiter.sv
// -----------------------------------------------------------------------------
// vc_arbiter
//
// Moves words from two virtual-channel FIFOs (VC0, VC1) into two destination
// FIFOs (D0, D1). Each word is routed by its bit DEST_BIT
// (0 -> D0, 1 -> D1). A three-state FSM (IDLE / FORWARD / PAUSE) decides
// when popping is allowed. Each popped word goes through a fixed two-stage
// pipeline:
//   cycle N   : pop_vcX strobe
//   cycle N+1 : VC read data valid, captured into the holding register
//   cycle N+2 : push_dX strobe with data_out = captured word
//
// Strobe semantics: pop_vc0/pop_vc1/push_d0/push_d1 are single-cycle
// fire-and-forget strobes. A pop is issued only when the selected VC is
// non-empty and neither destination is almost full; the destinations
// guarantee at least two free entries at their threshold, so the up to two
// words already in flight are always pushed without back-pressure.
//
// Parameters:
//   BITNUMBER : width of every data word
//   DEST_BIT  : index of the data bit selecting the destination
//
// Optional feature (macro VC_ROUND_ROBIN_EN):
//   defined   : round-robin between VCs when both are non-empty; last_grant
//               remembers the VC popped most recently.
//   undefined : strict priority, VC0 always wins when non-empty.
//
// Ports:
//   clk, reset                     : clock, synchronous active-high reset
//   active                         : forwarding enable from the main FSM
//   vc0_empty, vc1_empty           : VC FIFO empty flags
//   vc0_data, vc1_data             : VC FIFO read data (valid cycle after pop)
//   d0_almost_full, d1_almost_full : destination threshold flags
//   pop_vc0, pop_vc1               : VC FIFO read strobes
//   push_d0, push_d1               : destination FIFO write strobes
//   data_out                       : word written to D0/D1 (holds last value)
//   arb_pause                      : a VC has data but popping is blocked
//   arb_state                      : current FSM state (debug/observation)
// -----------------------------------------------------------------------------
module vc_arbiter #(
  parameter int BITNUMBER = 6,
  parameter int DEST_BIT  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 active,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [BITNUMBER-1:0] vc0_data,
  input  logic [BITNUMBER-1:0] vc1_data,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 arb_pause,
  output logic [1:0]           arb_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    PAUSE   = 2'd2
  } state_t;

  state_t               state;
  state_t               next_state;

  logic                 any_af;
  logic                 any_req;
  logic                 grant_vc1;
  logic                 pop_en;

  // Pipeline stage 1: a pop was issued last cycle, read data is on the bus now.
  logic                 p1_valid;
  logic                 p1_sel;
  // Pipeline stage 2: captured word, pushed this cycle when hold_valid is set.
  logic                 hold_valid;
  logic [BITNUMBER-1:0] hold_data;

  assign any_af  = d0_almost_full | d1_almost_full;
  assign any_req = ~vc0_empty | ~vc1_empty;

  // ---------------------------------------------------------------------------
  // VC selection
  // ---------------------------------------------------------------------------
`ifdef VC_ROUND_ROBIN_EN
  // 1 = VC1 was popped most recently. Resets to VC1 so VC0 wins first.
  logic last_grant;

  always_comb begin
    grant_vc1 = vc0_empty;
    if (!vc0_empty && !vc1_empty) begin
      grant_vc1 = ~last_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (pop_en) begin
      last_grant <= grant_vc1;
    end
  end
`else
  always_comb begin
    grant_vc1 = vc0_empty;
  end
`endif

  // Pops come straight from the registered state and current inputs. The
  // active term stops popping in the single cycle between active falling
  // and the FSM reaching IDLE.
  assign pop_en  = ~reset & active & (state == FORWARD) & ~any_af & any_req;
  assign pop_vc0 = pop_en & ~grant_vc1;
  assign pop_vc1 = pop_en &  grant_vc1;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    if (!active) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) next_state = FORWARD;
        end
        FORWARD: begin
          if (!any_req)    next_state = IDLE;
          else if (any_af) next_state = PAUSE;
        end
        PAUSE: begin
          if (!any_af) next_state = FORWARD;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      p1_valid   <= 1'b0;
      p1_sel     <= 1'b0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else begin
      state      <= next_state;
      p1_valid   <= pop_vc0 | pop_vc1;
      p1_sel     <= pop_vc1;
      hold_valid <= p1_valid;
      // hold_data changes only when a word is captured, and every captured
      // word is pushed the next cycle, so it always equals the last pushed
      // word once the push happens.
      if (p1_valid) begin
        hold_data <= p1_sel ? vc1_data : vc0_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign push_d0   = ~reset & hold_valid & ~hold_data[DEST_BIT];
  assign push_d1   = ~reset & hold_valid &  hold_data[DEST_BIT];
  assign data_out  = hold_data;
  assign arb_state = reset ? 2'd0 : state;
  assign arb_pause = ~reset & ((state == PAUSE) |
                               (active & any_req & any_af & (state != PAUSE)));

endmodule

// File: tb/tb_vc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vc_arbiter
//
// Directed bench for vc_arbiter. Two small VC FIFO models feed the DUT; the
// stimulus loads words and pushes the expected pop order and expected
// (destination, word) pairs into queues. A monitor on the falling edge pops
// and compares whenever the DUT strobes a pop or a push, and also checks the
// pop-to-push latency of two cycles.
// -----------------------------------------------------------------------------
module tb_vc_arbiter;

  localparam int W = 6;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUT
  // ---------------------------------------------------------------------------
  logic         active = 1'b0;
  logic         vc0_empty, vc1_empty;
  logic [W-1:0] vc0_data = '0;
  logic [W-1:0] vc1_data = '0;
  logic         d0_almost_full = 1'b0;
  logic         d1_almost_full = 1'b0;
  logic         pop_vc0, pop_vc1, push_d0, push_d1, arb_pause;
  logic [W-1:0] data_out;
  logic [1:0]   arb_state;

  vc_arbiter #(.BITNUMBER(W), .DEST_BIT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .active         (active),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_data       (vc0_data),
    .vc1_data       (vc1_data),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .push_d0        (push_d0),
    .push_d1        (push_d1),
    .data_out       (data_out),
    .arb_pause      (arb_pause),
    .arb_state      (arb_state)
  );

  // ---------------------------------------------------------------------------
  // VC FIFO models: empty flag updates at the popping edge, data the cycle after
  // ---------------------------------------------------------------------------
  logic [W-1:0] vc0_mem [32];
  logic [W-1:0] vc1_mem [32];
  int vc0_rd = 0, vc0_wr = 0, vc1_rd = 0, vc1_wr = 0;

  assign vc0_empty = (vc0_rd == vc0_wr);
  assign vc1_empty = (vc1_rd == vc1_wr);

  always @(posedge clk) begin
    if (pop_vc0) begin
      vc0_data <= vc0_mem[vc0_rd[4:0]];
      vc0_rd   <= vc0_rd + 1;
    end
    if (pop_vc1) begin
      vc1_data <= vc1_mem[vc1_rd[4:0]];
      vc1_rd   <= vc1_rd + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [W:0] exp_q[$];       // {dest, word}
  logic       exp_pop_q[$];   // 0 = VC0, 1 = VC1
  int         pop_stamp_q[$];
  int         push_cyc_q[$];
  int         push_cnt = 0;
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (reset) begin
      pop_stamp_q.delete();
    end else begin
      if (pop_vc0 || pop_vc1) begin
        chk("pop_onehot", {30'd0, pop_vc0, pop_vc1} == 32'd3, 32'd0);
        chk("pop_nonempty", (pop_vc0 && vc0_empty) || (pop_vc1 && vc1_empty), 32'd0);
        if (exp_pop_q.size() == 0) begin
          chk("unexpected_pop", 32'd1, 32'd0);
        end else begin
          chk("pop_order", {31'd0, pop_vc1}, {31'd0, exp_pop_q.pop_front()});
        end
        pop_stamp_q.push_back(cyc);
      end
      if (push_d0 || push_d1) begin
        logic [W:0] e;
        push_cnt++;
        push_cyc_q.push_back(cyc);
        chk("push_onehot", {30'd0, push_d0, push_d1} == 32'd3, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_push", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("push_dest", {31'd0, push_d1}, {31'd0, e[W]});
          chk("push_data", {26'd0, data_out}, {26'd0, e[W-1:0]});
        end
        if (pop_stamp_q.size() == 0) begin
          chk("push_without_pop", 32'd1, 32'd0);
        end else begin
          chk("push_latency", cyc - pop_stamp_q.pop_front(), 32'd2);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vc0(input logic [W-1:0] w);
    vc0_mem[vc0_wr[4:0]] = w;
    vc0_wr++;
  endtask

  task automatic load_vc1(input logic [W-1:0] w);
    vc1_mem[vc1_wr[4:0]] = w;
    vc1_wr++;
  endtask

  task automatic exp_pop(input logic vc);
    exp_pop_q.push_back(vc);
  endtask

  task automatic exp_push(input logic dest, input logic [W-1:0] w);
    exp_q.push_back({dest, w});
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && exp_pop_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk({name, "_pushes_left"}, exp_q.size(), 32'd0);
    chk({name, "_pops_left"}, exp_pop_q.size(), 32'd0);
    step();
    step();
  endtask

  task automatic wait_pop(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pop_vc0 || pop_vc1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, "_pop_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int pc;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_state", {30'd0, arb_state}, 32'd0);
    chk("rst_pop_vc0", {31'd0, pop_vc0}, 32'd0);
    chk("rst_pop_vc1", {31'd0, pop_vc1}, 32'd0);
    chk("rst_push_d0", {31'd0, push_d0}, 32'd0);
    chk("rst_push_d1", {31'd0, push_d1}, 32'd0);
    chk("rst_pause", {31'd0, arb_pause}, 32'd0);
    chk("rst_data_out", {26'd0, data_out}, 32'd0);
    step();
    reset = 1'b0;

    // Single word from VC0, bit4=0 -> D0
    active = 1'b1;
    load_vc0(6'h05);
    exp_pop(1'b0);
    exp_push(1'b0, 6'h05);
    @(negedge clk);
    chk("t1_idle_first", {30'd0, arb_state}, 32'd0);
    drain("t1", 20);
    chk("t1_data_out_hold", {26'd0, data_out}, 32'h05);

    // Two words from VC1, both to D1, back-to-back
    push_cyc_q.delete();
    load_vc1(6'h13);
    load_vc1(6'h31);
    exp_pop(1'b1);
    exp_pop(1'b1);
    exp_push(1'b1, 6'h13);
    exp_push(1'b1, 6'h31);
    drain("t2", 20);
    chk("t2_push_count", push_cyc_q.size(), 32'd2);
    if (push_cyc_q.size() == 2) begin
      chk("t2_back_to_back", push_cyc_q[1] - push_cyc_q[0], 32'd1);
    end

    // Both VCs hold four words
    load_vc0(6'h01); load_vc0(6'h12); load_vc0(6'h23); load_vc0(6'h34);
    load_vc1(6'h15); load_vc1(6'h06); load_vc1(6'h3F); load_vc1(6'h28);
`ifdef VC_ROUND_ROBIN_EN
    exp_pop(1'b0); exp_push(1'b0, 6'h01);
    exp_pop(1'b1); exp_push(1'b1, 6'h15);
    exp_pop(1'b0); exp_push(1'b1, 6'h12);
    exp_pop(1'b1); exp_push(1'b0, 6'h06);
    exp_pop(1'b0); exp_push(1'b0, 6'h23);
    exp_pop(1'b1); exp_push(1'b1, 6'h3F);
    exp_pop(1'b0); exp_push(1'b1, 6'h34);
    exp_pop(1'b1); exp_push(1'b0, 6'h28);
`else
    exp_pop(1'b0); exp_push(1'b0, 6'h01);
    exp_pop(1'b0); exp_push(1'b1, 6'h12);
    exp_pop(1'b0); exp_push(1'b0, 6'h23);
    exp_pop(1'b0); exp_push(1'b1, 6'h34);
    exp_pop(1'b1); exp_push(1'b1, 6'h15);
    exp_pop(1'b1); exp_push(1'b0, 6'h06);
    exp_pop(1'b1); exp_push(1'b1, 6'h3F);
    exp_pop(1'b1); exp_push(1'b0, 6'h28);
`endif
    drain("t3", 60);

    // d0_almost_full rises one cycle after a pop
    load_vc0(6'h02); load_vc0(6'h03); load_vc0(6'h07);
    exp_pop(1'b0); exp_push(1'b0, 6'h02);
    exp_pop(1'b0); exp_push(1'b0, 6'h03);
    exp_pop(1'b0); exp_push(1'b0, 6'h07);
    wait_pop("t4");
    @(posedge clk);
    #1;
    d0_almost_full = 1'b1;
    @(negedge clk);
    chk("t4_n1_no_pop", {30'd0, pop_vc0, pop_vc1}, 32'd0);
    chk("t4_n1_pause", {31'd0, arb_pause}, 32'd1);
    step();
    @(negedge clk);
    chk("t4_n2_state", {30'd0, arb_state}, 32'd2);
    chk("t4_n2_pause", {31'd0, arb_pause}, 32'd1);
    chk("t4_n2_no_pop", {30'd0, pop_vc0, pop_vc1}, 32'd0);
    chk("t4_n2_inflight_push", {31'd0, push_d0}, 32'd1);
    step();
    @(negedge clk);
    chk("t4_n3_state", {30'd0, arb_state}, 32'd2);
    chk("t4_n3_no_pop", {30'd0, pop_vc0, pop_vc1}, 32'd0);
    step();
    d0_almost_full = 1'b0;
    @(negedge clk);
    chk("t4_release_still_pause", {30'd0, arb_state}, 32'd2);
    step();
    @(negedge clk);
    chk("t4_resume_state", {30'd0, arb_state}, 32'd1);
    chk("t4_resume_pop", {31'd0, pop_vc0}, 32'd1);
    drain("t4", 20);

    // active=0 with non-empty VCs, then enable and drain
    active = 1'b0;
    load_vc0(6'h10);
    load_vc1(6'h0A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_pop", {30'd0, pop_vc0, pop_vc1}, 32'd0);
      chk("t5_state", {30'd0, arb_state}, 32'd0);
      chk("t5_pause", {31'd0, arb_pause}, 32'd0);
    end
    step();
    active = 1'b1;
`ifdef VC_ROUND_ROBIN_EN
    exp_pop(1'b1); exp_push(1'b0, 6'h0A);
    exp_pop(1'b0); exp_push(1'b1, 6'h10);
`else
    exp_pop(1'b0); exp_push(1'b1, 6'h10);
    exp_pop(1'b1); exp_push(1'b0, 6'h0A);
`endif
    drain("t5", 20);

    // Reset the cycle after a pop: the in-flight word is dropped
    load_vc0(6'h09);
    exp_pop(1'b0);
    wait_pop("t6");
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_pop", {30'd0, pop_vc0, pop_vc1}, 32'd0);
    chk("t6_rst_push", {30'd0, push_d0, push_d1}, 32'd0);
    chk("t6_rst_pause", {31'd0, arb_pause}, 32'd0);
    chk("t6_rst_state", {30'd0, arb_state}, 32'd0);
    step();
    reset = 1'b0;
    pc = push_cnt;
    repeat (5) @(negedge clk);
    chk("t6_no_push_after", push_cnt - pc, 32'd0);
    chk("t6_state_idle", {30'd0, arb_state}, 32'd0);
    chk("t6_data_out_zero", {26'd0, data_out}, 32'd0);
    chk("t6_pops_left", exp_pop_q.size(), 32'd0);

    chk("final_pushes_left", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 SHALL have parameter BITNUMBER, default 6, width of every data word.
REQ-002 SHALL have parameter DEST_BIT, default 4, index of the data bit that selects the destination (0 -> D0, 1 -> D1).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port active  input  1  enable from the main transaction FSM; high = forwarding allowed.
REQ-006 SHALL have ports vc0_empty, vc1_empty  input  1 each  empty flags of VC0/VC1 FIFOs; each updates at the same edge that consumes a pop.
REQ-007 SHALL have ports vc0_data, vc1_data  input  BITNUMBER each  VC FIFO read data; valid the cycle after the pop.
REQ-008 SHALL have ports d0_almost_full, d1_almost_full  input  1 each  destination FIFO threshold flags.
REQ-009 SHALL have ports pop_vc0, pop_vc1  output  1 each  VC FIFO read strobes.
REQ-010 SHALL have ports push_d0, push_d1  output  1 each  destination FIFO write strobes.
REQ-011 SHALL have port data_out  output  BITNUMBER  word written to D0/D1.
REQ-012 SHALL have port arb_pause  output  1  high when a VC is non-empty but popping is blocked.
REQ-013 SHALL have port arb_state  output  2  current FSM state encoding.

Function
REQ-014 SHALL implement FSM states IDLE=0, FORWARD=1, PAUSE=2; encoding 3 is unreachable and SHALL return to IDLE.
REQ-015 SHALL transition IDLE->FORWARD when active=1 and at least one VC is non-empty.
REQ-016 SHALL transition FORWARD->PAUSE when d0_almost_full or d1_almost_full is high, and PAUSE->FORWARD when both are low.
REQ-017 SHALL transition any state->IDLE when active=0, or in FORWARD when both VCs are empty.
REQ-018 SHALL assert at most one pop per cycle, only in FORWARD, only when the selected VC is non-empty and both almost_full flags are low; pops SHALL be combinational from registered state and current inputs.
REQ-019 SHALL pipeline each pop: cycle N pop, cycle N+1 capture the VC data into a holding register with a valid bit, cycle N+2 push_dX=1 with data_out equal to the captured word (latency 2, throughput 1 word/cycle).
REQ-020 SHALL route a captured word to D1 if word[DEST_BIT]=1, else to D0; push_d0 and push_d1 SHALL never both be high.
REQ-021 SHALL always complete in-flight words (up to 2) even after entering PAUSE or IDLE; destination thresholds SHALL leave at least 2 free entries.
REQ-022 SHALL assert arb_pause in PAUSE, and in FORWARD/IDLE when active=1, a VC is non-empty and a pop is blocked by an almost_full flag.
REQ-023 SHALL hold data_out at its last pushed value when no push occurs.

Reset
REQ-024 SHALL, on reset=1 at a rising edge, set the FSM to IDLE, clear both pipeline valid bits, set last_grant to VC1 (so VC0 wins first), and zero data_out.
REQ-025 SHALL drive pop_vc0, pop_vc1, push_d0, push_d1, arb_pause low and arb_state=0 while reset is high.
REQ-026 SHALL discard any in-flight word when reset asserts mid-transfer; no push SHALL follow reset release for that word.

Configuration
REQ-027 SHALL support macro VC_ROUND_ROBIN_EN.
REQ-028 SHALL, with VC_ROUND_ROBIN_EN defined, grant the VC not granted last when both are non-empty, updating last_grant on each pop.
REQ-029 SHALL, without VC_ROUND_ROBIN_EN, grant VC0 whenever it is non-empty (strict priority); last_grant SHALL not exist.

Verification
REQ-030 SHALL cover: reset, active=1, VC0 holds 0x05 (bit4=0) -> pop_vc0 at N, push_d0=1 with data_out=0x05 at N+2, push_d1=0.
REQ-031 SHALL cover: VC1 holds 0x13 then 0x31 -> back-to-back pops; push_d1 with 0x13 at N+2, push_d1 with 0x31 at N+3.
REQ-032 SHALL cover: both VCs hold 4 words, macro defined -> pop order VC0,VC1,VC0,VC1,...; macro undefined -> all 4 VC0 pops before any VC1 pop.
REQ-033 SHALL cover: d0_almost_full rises one cycle after a pop -> arb_state=2, arb_pause=1, no further pops, the in-flight word still pushed; flag low -> FORWARD resumes next cycle.
REQ-034 SHALL cover: reset asserted the cycle after a pop -> no push in the following cycles, all outputs 0, arb_state=0.
REQ-035 SHALL cover: active=0 with non-empty VCs -> no pops, arb_state=0, arb_pause=0.
